mips_fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the MIPS core.
- Replaces the single-cycle `pc_current`/`pc_next` register with a decoupled, latency-tolerant fetch stage:
  - issues in-order requests to instruction memory over a valid/ready handshake;
  - buffers returned instructions in a DEPTH-entry queue;
  - presents them to decode with their PC and PC+4;
  - handles branch/jump/jr redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/mips_pkg.sv | 13 +
 rtl/mips_fetch_queue.sv | 57 +++++
 rtl/mips_fetch_unit.sv | 93 +++++++++
 tb/tb_mips_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS instruction-fetch front end.
package mips_pkg;

    localparam int unsigned DEF_XLEN = 32;
    localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_STEP = 4;

    typedef struct packed {
        logic [DEF_XLEN-1:0] instr;
        logic [DEF_XLEN-1:0] pc;
    } if_entry_t;

endpackage

// File: rtl/mips_fetch_queue.sv
// Synchronous FIFO of fetched {instr, pc} entries with flush; DEPTH must be a power of 2.
module mips_fetch_queue
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  if_entry_t     i_wdata,
    output if_entry_t     o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full
);

    if_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/mips_fetch_unit.sv
// Decoupled instruction fetch: credit-limited in-order requests, response queue, redirect flush.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned     XLEN     = DEF_XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
    localparam int unsigned    CW       = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc4
);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   w_count;
    logic            w_empty;
    logic            w_full;
    logic            w_req_fire;
    logic            w_rsp_keep;
    logic            w_pop;
    logic [XLEN-1:0] w_target;
    if_entry_t       w_wdata;
    if_entry_t       w_head;
    logic            w_unused;

    assign w_unused = &{1'b0, redirect_pc[1:0]};
    assign w_target = {redirect_pc[XLEN-1:2], 2'b00};

    // Queued entries plus in-flight requests never exceed DEPTH, so the queue cannot overflow.
    assign imem_req_valid = !rst && !redirect_valid && ((w_count + r_outstanding) < CW'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_rsp_keep     = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop          = out_valid && out_ready;
    assign w_wdata        = '{instr: imem_rsp_data, pc: r_rsp_pc};

    // r_outstanding counts every request in flight, including those already marked for dropping,
    // so on redirect everything still in flight after this edge becomes a drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= w_target;
            r_rsp_pc      <= w_target;
            r_outstanding <= r_outstanding - CW'(imem_rsp_valid);
            r_drop_cnt    <= r_outstanding - CW'(imem_rsp_valid);
        end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
            if (w_rsp_keep) r_rsp_pc   <= r_rsp_pc + XLEN'(PC_STEP);
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
        end
    end

    mips_fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rsp_keep && (!w_full || w_pop)),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign out_valid = !w_empty;
    assign out_instr = out_valid ? w_head.instr : '0;
    assign out_pc    = out_valid ? w_head.pc : '0;
    assign out_pc4   = out_valid ? (w_head.pc + XLEN'(PC_STEP)) : '0;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with an in-order, fixed-latency instruction memory model.
module tb_mips_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        ordy;
        logic        rv;
        logic [31:0] addr;
        logic        ov;
        logic [31:0] opc;
    } vec_t;

    pend_t mem_q[$];
    vec_t  vecs[6];
    int    lat;
    int    cyc;
    int    n_pass;
    int    n_total;

    mips_fetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc4        (out_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'h8C00_0000 ^ {a[15:0], 16'h0000};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock: capture the handshake, advance, then drive this cycle's memory response.
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        pend_t       p;
        #1;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        @(posedge clk);
        #1;
        if (hs) begin
            p.addr = a;
            p.due  = cyc + lat;
            mem_q.push_back(p);
        end
        cyc++;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = imem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        mem_q.delete();
        cyc = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    // Wait (bounded) for the next delivered instruction, check it, then let it pop.
    task automatic expect_out(input string name, input logic [31:0] exp_pc);
        int i;
        i = 0;
        #1;
        while (!out_valid && i < 30) begin
            tick();
            #1;
            i++;
        end
        chk({name, " valid"}, 32'(out_valid), 32'd1);
        chk({name, " pc"}, out_pc, exp_pc);
        chk({name, " instr"}, out_instr, imem_word(exp_pc));
        chk({name, " pc4"}, out_pc4, exp_pc + 32'd4);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nreq;
        int          bad;
        int          seq_bad;
        logic        prev_stall;
        logic [31:0] prev_addr;
        logic [31:0] exp_pc;

        n_pass  = 0;
        n_total = 0;
        lat     = 1;

        vecs[0] = '{ordy: 1'b1, rv: 1'b1, addr: 32'h00, ov: 1'b0, opc: 32'h00};
        vecs[1] = '{ordy: 1'b1, rv: 1'b1, addr: 32'h04, ov: 1'b0, opc: 32'h00};
        vecs[2] = '{ordy: 1'b1, rv: 1'b1, addr: 32'h08, ov: 1'b1, opc: 32'h00};
        vecs[3] = '{ordy: 1'b1, rv: 1'b1, addr: 32'h0C, ov: 1'b1, opc: 32'h04};
        vecs[4] = '{ordy: 1'b1, rv: 1'b1, addr: 32'h10, ov: 1'b1, opc: 32'h08};
        vecs[5] = '{ordy: 1'b1, rv: 1'b1, addr: 32'h14, ov: 1'b1, opc: 32'h0C};

        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        #3;
        chk("reset req_valid", 32'(imem_req_valid), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_instr", out_instr, 32'd0);
        chk("reset out_pc", out_pc, 32'd0);
        chk("reset out_pc4", out_pc4, 32'd0);

        // Streaming, latency 1
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            out_ready = vecs[k].ordy;
            #1;
            chk($sformatf("stream[%0d] req_valid", k), 32'(imem_req_valid), 32'(vecs[k].rv));
            chk($sformatf("stream[%0d] req_addr", k), imem_req_addr, vecs[k].addr);
            chk($sformatf("stream[%0d] out_valid", k), 32'(out_valid), 32'(vecs[k].ov));
            if (vecs[k].ov) begin
                chk($sformatf("stream[%0d] out_pc", k), out_pc, vecs[k].opc);
                chk($sformatf("stream[%0d] out_instr", k), out_instr, imem_word(vecs[k].opc));
                chk($sformatf("stream[%0d] out_pc4", k), out_pc4, vecs[k].opc + 32'd4);
            end
            tick();
        end

        // Back-pressure: credits cap issue at DEPTH requests
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        out_ready = 1'b0;
        nreq = 0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (imem_req_valid && imem_req_ready) nreq++;
            if (k >= 2 && (out_pc !== 32'h0 || out_instr !== imem_word(32'h0) || !out_valid)) bad++;
            tick();
        end
        #1;
        chk("bp request count", 32'(nreq), 32'd4);
        chk("bp req_valid stalled", 32'(imem_req_valid), 32'd0);
        chk("bp head unstable cycles", 32'(bad), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp still stalled", 32'(imem_req_valid), 32'd0);
        tick();
        #1;
        chk("bp resume req_valid", 32'(imem_req_valid), 32'd1);
        chk("bp resume addr", imem_req_addr, 32'h10);
        chk("bp resume out_pc", out_pc, 32'h04);

        // Redirect with two stale requests in flight, latency 3
        do_reset();
        lat = 3;
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("redir no req", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("redir target req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir target addr", imem_req_addr, 32'h100);
        expect_out("redir first", 32'h100);
        expect_out("redir second", 32'h104);

        // Redirect on a response + pop, then back-to-back redirect, latency 2
        do_reset();
        lat = 2;
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        repeat (5) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("b2b pre out_valid", 32'(out_valid), 32'd1);
        tick();
        redirect_pc = 32'h300;
        #1;
        chk("b2b flushed", 32'(out_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("b2b still empty", 32'(out_valid), 32'd0);
        chk("b2b target addr", imem_req_addr, 32'h300);
        expect_out("b2b first", 32'h300);
        expect_out("b2b second", 32'h304);

        // Random request ready: request must hold until accepted; stream stays in order
        do_reset();
        lat = 1;
        out_ready = 1'b1;
        bad = 0;
        seq_bad = 0;
        prev_stall = 1'b0;
        prev_addr = '0;
        exp_pc = '0;
        for (int k = 0; k < 60; k++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall && (!imem_req_valid || imem_req_addr !== prev_addr)) bad++;
            if (out_valid) begin
                if (out_pc !== exp_pc) seq_bad++;
                exp_pc = exp_pc + 32'd4;
            end
            prev_stall = imem_req_valid && !imem_req_ready;
            prev_addr = imem_req_addr;
            tick();
        end
        chk("hs hold violations", 32'(bad), 32'd0);
        chk("hs order violations", 32'(seq_bad), 32'd0);
        chk("hs progress", 32'(exp_pc >= 32'h20), 32'd1);
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("align addr", imem_req_addr, 32'h100);
        expect_out("align", 32'h100);

        // Asynchronous reset between edges
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        repeat (6) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst req_valid", 32'(imem_req_valid), 32'd0);
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst out_pc", out_pc, 32'd0);
        chk("arst out_instr", out_instr, 32'd0);
        chk("arst out_pc4", out_pc4, 32'd0);
        mem_q.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        cyc = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("arst restart valid", 32'(imem_req_valid), 32'd1);
        chk("arst restart addr", imem_req_addr, 32'h0);
        expect_out("arst restart", 32'h0);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        expect_out("wrap last", 32'hFFFF_FFFC);
        expect_out("wrap zero", 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
